// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control path: opcodes, result/immediate selects,
// ALU operation codes and the per-stage control bundles.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Full 4-bit codes; the base subset uses the same values in 3 bits.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
    } ectl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [2:0] funct;
    } mctl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wctl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational D-stage decoder: opcode/funct fields to control bundle and ALU code.
// Ports: op, funct3, funct7b5 in; ctl, alu_ctrl, funct, imm_src, illegal out.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    output ectl_t                ctl,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [2:0]           funct,
    output logic [1:0]           imm_src,
    output logic                 illegal
);

    aluop_e     aluop;
    logic [3:0] alu_full;

    always_comb begin
        ctl     = '0;
        aluop   = ALUOP_ADD;
        imm_src = IMM_I;
        illegal = 1'b0;
        case (op)
            OP_LOAD: begin
                ctl.reg_write  = 1'b1;
                ctl.alu_src    = 1'b1;
                ctl.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctl.mem_write = 1'b1;
                ctl.alu_src   = 1'b1;
                imm_src       = IMM_S;
            end
            OP_RTYPE: begin
                ctl.reg_write = 1'b1;
                aluop         = ALUOP_FUNCT;
            end
            OP_IALU: begin
                ctl.reg_write = 1'b1;
                ctl.alu_src   = 1'b1;
                aluop         = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                ctl.branch = 1'b1;
                aluop      = ALUOP_SUB;
                imm_src    = IMM_B;
            end
            OP_JAL: begin
                ctl.reg_write  = 1'b1;
                ctl.jump       = 1'b1;
                ctl.result_src = RES_PC4;
                imm_src        = IMM_J;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign funct = illegal ? 3'b000 : funct3;

    always_comb begin
        alu_full = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_full = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        // bit 30 means sub only for register-register ops
                        if (op == OP_RTYPE && funct7b5)
                            alu_full = ALU_SUB;
                        else
                            alu_full = ALU_ADD;
                    end
                    3'b001: alu_full = ALU_SLL;
                    3'b010: alu_full = ALU_SLT;
                    3'b011: alu_full = ALU_SLTU;
                    3'b100: alu_full = ALU_XOR;
                    3'b101: alu_full = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_full = ALU_OR;
                    default: alu_full = ALU_AND;
                endcase
            end
            default: alu_full = ALU_ADD;
        endcase
    end

    generate
        if (ALUCTRL_W == 4) begin : g_full
            assign alu_ctrl = alu_full[ALUCTRL_W-1:0];
        end else begin : g_base
            // Operations outside the base ALU fall back to add.
            logic base_op;
            assign base_op = alu_full inside
                {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
            assign alu_ctrl = base_op ? alu_full[ALUCTRL_W-1:0] : '0;
        end
    endgenerate

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: decoded D controls flow through E, M, W stage registers.
// Ports: clk, reset, op/funct3/funct7b5 (D), stallE/flushE/flushM, takenE in;
//   ImmSrcD, illegalD, E/M/W controls, PCSrcE, perf_flush_cnt/perf_stall_cnt out.
// Macro CTRL_PIPE_PERF_EN enables the saturating flush/stall counters.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int PERF_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 stallE,
    input  logic                 flushE,
    input  logic                 flushM,
    input  logic                 takenE,
    output logic [1:0]           ImmSrcD,
    output logic                 illegalD,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 JumpE,
    output logic                 BranchE,
    output logic                 ALUSrcE,
    output logic [1:0]           ResultSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [2:0]           functE,
    output logic                 PCSrcE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic [1:0]           ResultSrcM,
    output logic [2:0]           functM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW,
    output logic [PERF_W-1:0]    perf_flush_cnt,
    output logic [PERF_W-1:0]    perf_stall_cnt
);

    ectl_t                ctl_d;
    logic [ALUCTRL_W-1:0] alu_d;
    logic [2:0]           funct_d;

    ectl_t                e_q;
    logic [ALUCTRL_W-1:0] alu_e;
    logic [2:0]           funct_e;
    mctl_t                m_q;
    wctl_t                w_q;

    ctrl_decode #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_dec (
        .op      (op),
        .funct3  (funct3),
        .funct7b5(funct7b5),
        .ctl     (ctl_d),
        .alu_ctrl(alu_d),
        .funct   (funct_d),
        .imm_src (ImmSrcD),
        .illegal (illegalD)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q     <= '0;
            alu_e   <= '0;
            funct_e <= '0;
            m_q     <= '0;
            w_q     <= '0;
        end else begin
            if (flushE) begin
                e_q     <= '0;
                alu_e   <= '0;
                funct_e <= '0;
            end else if (!stallE) begin
                e_q     <= ctl_d;
                alu_e   <= alu_d;
                funct_e <= funct_d;
            end
            // A held E instruction must not also advance into M.
            if (stallE || flushM)
                m_q <= '0;
            else
                m_q <= '{e_q.reg_write, e_q.mem_write,
                         e_q.result_src, funct_e};
            w_q <= '{m_q.reg_write, m_q.result_src};
        end
    end

    assign RegWriteE   = e_q.reg_write;
    assign MemWriteE   = e_q.mem_write;
    assign JumpE       = e_q.jump;
    assign BranchE     = e_q.branch;
    assign ALUSrcE     = e_q.alu_src;
    assign ResultSrcE  = e_q.result_src;
    assign ALUControlE = alu_e;
    assign functE      = funct_e;
    assign PCSrcE      = e_q.jump | (e_q.branch & takenE);

    assign RegWriteM  = m_q.reg_write;
    assign MemWriteM  = m_q.mem_write;
    assign ResultSrcM = m_q.result_src;
    assign functM     = m_q.funct;

    assign RegWriteW  = w_q.reg_write;
    assign ResultSrcW = w_q.result_src;

`ifdef CTRL_PIPE_PERF_EN
    logic [PERF_W-1:0] flush_cnt;
    logic [PERF_W-1:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (flushE && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
            // A flush overrides a stall, so that edge is not a stall.
            if (stallE && !flushE && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign perf_flush_cnt = flush_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_flush_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: a 3-bit/16-bit-counter instance and a
// 4-bit/4-bit-counter instance share one randomized stimulus stream.
module tb_ctrl_pipe;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

`ifdef CTRL_PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0;
    logic stallE = 1'b0, flushE = 1'b0, flushM = 1'b0, takenE = 1'b0;

    always #5 clk = ~clk;

    logic [1:0] a_imm, a_rsE, a_rsM, a_rsW;
    logic a_ill, a_rwE, a_mwE, a_jE, a_bE, a_asE, a_pcs;
    logic a_rwM, a_mwM, a_rwW;
    logic [2:0] a_aluE, a_fE, a_fM;
    logic [15:0] a_fc, a_sc;

    logic [1:0] b_imm, b_rsE, b_rsM, b_rsW;
    logic b_ill, b_rwE, b_mwE, b_jE, b_bE, b_asE, b_pcs;
    logic b_rwM, b_mwM, b_rwW;
    logic [3:0] b_aluE;
    logic [2:0] b_fE, b_fM;
    logic [3:0] b_fc, b_sc;

    ctrl_pipe #(.ALUCTRL_W(3), .PERF_W(16)) u_a (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .stallE(stallE), .flushE(flushE),
        .flushM(flushM), .takenE(takenE),
        .ImmSrcD(a_imm), .illegalD(a_ill),
        .RegWriteE(a_rwE), .MemWriteE(a_mwE), .JumpE(a_jE),
        .BranchE(a_bE), .ALUSrcE(a_asE), .ResultSrcE(a_rsE),
        .ALUControlE(a_aluE), .functE(a_fE), .PCSrcE(a_pcs),
        .RegWriteM(a_rwM), .MemWriteM(a_mwM), .ResultSrcM(a_rsM),
        .functM(a_fM), .RegWriteW(a_rwW), .ResultSrcW(a_rsW),
        .perf_flush_cnt(a_fc), .perf_stall_cnt(a_sc)
    );

    ctrl_pipe #(.ALUCTRL_W(4), .PERF_W(4)) u_b (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .stallE(stallE), .flushE(flushE),
        .flushM(flushM), .takenE(takenE),
        .ImmSrcD(b_imm), .illegalD(b_ill),
        .RegWriteE(b_rwE), .MemWriteE(b_mwE), .JumpE(b_jE),
        .BranchE(b_bE), .ALUSrcE(b_asE), .ResultSrcE(b_rsE),
        .ALUControlE(b_aluE), .functE(b_fE), .PCSrcE(b_pcs),
        .RegWriteM(b_rwM), .MemWriteM(b_mwM), .ResultSrcM(b_rsM),
        .functM(b_fM), .RegWriteW(b_rwW), .ResultSrcW(b_rsW),
        .perf_flush_cnt(b_fc), .perf_stall_cnt(b_sc)
    );

    // Instruction-level view of the controls one instruction carries.
    typedef struct packed {
        logic rw, mw, j, b, as;
        logic [1:0] rs;
        logic [3:0] alu4;
        logic [2:0] f;
    } ctl_t;

    ctl_t me = '0, mm = '0, mw = '0;
    int fcnt = 0, scnt = 0;
    int total = 0, bad = 0;

    function automatic void check(string n, logic [63:0] g, logic [63:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, g, e);
        end
    endfunction

    function automatic ctl_t dec(logic [6:0] o, logic [2:0] f3, logic f7);
        ctl_t c = '0;
        logic [3:0] fa;
        case (f3)
            3'd0: fa = (o == RT && f7) ? 4'd1 : 4'd0;
            3'd1: fa = 4'd6;
            3'd2: fa = 4'd5;
            3'd3: fa = 4'd9;
            3'd4: fa = 4'd4;
            3'd5: fa = f7 ? 4'd8 : 4'd7;
            3'd6: fa = 4'd3;
            default: fa = 4'd2;
        endcase
        case (o)
            LW: begin c.rw = 1; c.as = 1; c.rs = 2'b01; end
            SW: begin c.mw = 1; c.as = 1; end
            RT: begin c.rw = 1; c.alu4 = fa; end
            IT: begin c.rw = 1; c.as = 1; c.alu4 = fa; end
            BR: begin c.b = 1; c.alu4 = 4'd1; end
            JL: begin c.rw = 1; c.j = 1; c.rs = 2'b10; end
            default: return '0;
        endcase
        c.f = f3;
        return c;
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] o);
        case (o)
            SW: return 2'b01;
            BR: return 2'b10;
            JL: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic legal(logic [6:0] o);
        return o inside {LW, SW, RT, IT, BR, JL};
    endfunction

    // 3-bit ALU only implements add/sub/and/or/slt; anything else is add.
    function automatic logic [3:0] base3(logic [3:0] a);
        return (a inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5}) ? a : 4'd0;
    endfunction

    function automatic logic [15:0] sat(int c, int w);
        int mx = (1 << w) - 1;
        if (!PERF) return 16'd0;
        return 16'(c > mx ? mx : c);
    endfunction

    task automatic clr_model();
        me = '0; mm = '0; mw = '0;
        fcnt = 0; scnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            clr_model();
        end else begin
            if (flushE) fcnt++;
            else if (stallE) scnt++;
            mw = mm;
            mm = (stallE || flushM) ? '0 : me;
            if (flushE) me = '0;
            else if (!stallE) me = dec(op, funct3, funct7b5);
        end
        #1;
    endtask

    task automatic set(logic [6:0] o, logic [2:0] f3, logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    always @(negedge clk) begin
        logic [3:0] a3;
        logic [3:0] f4, s4;
        a3 = base3(me.alu4);
        f4 = 4'(sat(fcnt, 4));
        s4 = 4'(sat(scnt, 4));
        check("a_comb", {a_imm, a_ill, a_pcs},
              {imm_of(op), !legal(op), me.j | (me.b & takenE)});
        check("b_comb", {b_imm, b_ill, b_pcs},
              {imm_of(op), !legal(op), me.j | (me.b & takenE)});
        check("a_E", {a_rwE, a_mwE, a_jE, a_bE, a_asE, a_rsE, a_aluE, a_fE},
              {me.rw, me.mw, me.j, me.b, me.as, me.rs, a3[2:0], me.f});
        check("b_E", {b_rwE, b_mwE, b_jE, b_bE, b_asE, b_rsE, b_aluE, b_fE},
              {me.rw, me.mw, me.j, me.b, me.as, me.rs, me.alu4, me.f});
        check("a_M", {a_rwM, a_mwM, a_rsM, a_fM}, {mm.rw, mm.mw, mm.rs, mm.f});
        check("b_M", {b_rwM, b_mwM, b_rsM, b_fM}, {mm.rw, mm.mw, mm.rs, mm.f});
        check("a_W", {a_rwW, a_rsW}, {mw.rw, mw.rs});
        check("b_W", {b_rwW, b_rsW}, {mw.rw, mw.rs});
        check("a_perf", {a_fc, a_sc}, {sat(fcnt, 16), sat(scnt, 16)});
        check("b_perf", {b_fc, b_sc}, {f4, s4});
    end

    initial begin
        logic [6:0] ops [6];
        ops[0] = LW; ops[1] = SW; ops[2] = RT;
        ops[3] = IT; ops[4] = BR; ops[5] = JL;

        tick();
        tick();
        check("reset_E", {a_rwE, a_rsE, a_aluE, a_fE, b_aluE}, '0);
        reset = 1'b0;

        // lw travels E -> M -> W
        set(LW, 3'b010, 1'b0);
        tick();
        check("lw_E", {a_rwE, a_rsE, a_asE, a_aluE}, {1'b1, 2'b01, 1'b1, 3'b000});
        set(7'h00, 3'b000, 1'b0);
        tick();
        check("lw_M", a_rwM, 1'b1);
        tick();
        check("lw_W", a_rsW, 2'b01);

        // stall holds addi in E, bubbles M, then sub arrives
        set(IT, 3'b000, 1'b0);
        tick();
        set(RT, 3'b000, 1'b1);
        stallE = 1'b1;
        tick();
        check("stall1_E", {a_rwE, a_asE, a_aluE}, {1'b1, 1'b1, 3'b000});
        check("stall1_M", {a_rwM, a_mwM, a_rsM, a_fM}, '0);
        tick();
        check("stall2_E", {a_rwE, a_asE, a_aluE}, {1'b1, 1'b1, 3'b000});
        check("stall2_M", {a_rwM, a_mwM, a_rsM, a_fM}, '0);
        stallE = 1'b0;
        tick();
        check("sub_a", a_aluE, 3'b001);
        check("sub_b", b_aluE, 4'b0001);

        // taken branch, then flush
        set(BR, 3'b000, 1'b0);
        tick();
        set(7'h00, 3'b000, 1'b0);
        takenE = 1'b1;
        #1;
        check("beq_pcs", a_pcs, 1'b1);
        flushE = 1'b1;
        tick();
        check("flush_E", {a_rwE, a_mwE, a_jE, a_bE, a_asE, a_rsE, a_aluE, a_fE}, '0);
        check("flush_cnt", a_fc, PERF ? 16'd1 : 16'd0);
        flushE = 1'b0;
        takenE = 1'b0;

        // illegal opcode
        set(7'h7f, 3'b111, 1'b1);
        #1;
        check("illegal", a_ill, 1'b1);
        tick();
        check("ill_E", {b_rwE, b_mwE, b_jE, b_bE, b_asE, b_rsE, b_aluE, b_fE}, '0);

        // sra only exists in the 4-bit ALU
        set(RT, 3'b101, 1'b1);
        tick();
        check("sra_a", a_aluE, 3'b000);
        check("sra_b", b_aluE, 4'b1000);

        // long stall saturates the 4-bit counter
        stallE = 1'b1;
        repeat (20) tick();
        check("sat4", b_sc, PERF ? 4'd15 : 4'd0);
        check("stall16", a_sc, PERF ? 16'd22 : 16'd0);
        stallE = 1'b0;

        for (int i = 0; i < 400; i++) begin
            int k;
            k = $urandom_range(0, 6);
            if (k == 6) set(7'($urandom), 3'($urandom), 1'($urandom));
            else set(ops[k], 3'($urandom), 1'($urandom));
            stallE = ($urandom_range(0, 4) == 0);
            flushE = ($urandom_range(0, 6) == 0);
            flushM = ($urandom_range(0, 9) == 0);
            takenE = 1'($urandom);
            if (i == 200) begin
                #2;
                reset = 1'b1;
                #1;
                check("rst_now_a",
                      {a_rwE, a_mwE, a_jE, a_bE, a_asE, a_rsE, a_aluE, a_fE,
                       a_rwM, a_mwM, a_rsM, a_fM, a_rwW, a_rsW, a_fc, a_sc}, '0);
                check("rst_now_b",
                      {b_rwE, b_mwE, b_jE, b_bE, b_asE, b_rsE, b_aluE, b_fE,
                       b_rwM, b_mwM, b_rsM, b_fM, b_rwW, b_rsW, b_fc, b_sc}, '0);
                clr_model();
                tick();
                tick();
                reset = 1'b0;
                stallE = 1'b0; flushE = 1'b0; flushM = 1'b0;
                set(LW, 3'b010, 1'b0);
                tick();
                check("rst_first", {a_rwE, a_rsE}, {1'b1, 2'b01});
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
